gate_adder_unit: RTL and testbench
==================================

GATE_ADDER_UNIT -- requirements
Module: gate_adder_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand bit width, legal range 1..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, marks a, b, op as a valid operation this cycle.
REQ-005 SHALL have port a, input, WIDTH, operand A.
REQ-006 SHALL have port b, input, WIDTH, operand B.
REQ-007 SHALL have port op, input, 2, operation select: 00 AND, 01 XOR, 10 HADD, 11 RCA.
REQ-008 SHALL have port y, output, WIDTH, registered result.
REQ-009 SHALL have port c, output, WIDTH, registered carry vector.
REQ-010 SHALL have port out_valid, output, 1, high when y and c hold a result captured from an in_valid cycle.

Function
REQ-011 SHALL use only 2-input AND and 2-input XOR cells for all combinational datapath logic: no OR, no "+" operator, no behavioural adders.
REQ-012 op=00: y = a AND b (bitwise); c = 0.
REQ-013 op=01: y = a XOR b (bitwise); c = 0.
REQ-014 op=10 (per-bit half adders): y[i] = a[i] XOR b[i]; c[i] = a[i] AND b[i]; no carry propagation between bits.
REQ-015 op=11 (ripple-carry add, carry-in 0): stage 0 is a half adder; stages 1..WIDTH-1 are full adders.
REQ-016 Full-adder sum SHALL be s = a[i] XOR b[i] XOR cin.
REQ-017 Full-adder carry SHALL be co = (a[i] AND b[i]) XOR (cin AND (a[i] XOR b[i])); the XOR is legal because the two terms are mutually exclusive.
REQ-018 op=11: y = (a+b) mod 2^WIDTH; c[i] = carry-out of stage i; c[WIDTH-1] is the final carry-out.
REQ-019 Latency SHALL be exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on y and c after edge N.
REQ-020 out_valid SHALL be a registered copy of in_valid with the same 1-cycle latency.
REQ-021 When in_valid=0 at an edge, y and c SHALL hold their previous values and out_valid SHALL go 0.
REQ-022 Back-to-back in_valid cycles SHALL each produce a result on consecutive cycles; there is no backpressure.
REQ-023 Overflow in op=11 SHALL wrap y modulo 2^WIDTH, with the overflow visible only in c[WIDTH-1].
REQ-024 op changing between cycles SHALL take effect on the next valid sample with no residual state; the block has no internal state beyond the output registers.

Reset
REQ-025 While rst=1, y, c and out_valid SHALL be 0 immediately, without waiting for a clock edge.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result; the first result after release comes from the first in_valid edge after rst falls.
REQ-027 in_valid sampled at an edge while rst=1 SHALL be ignored.

Verification
REQ-028 WIDTH=4, op=10: (a,b) bit0 pairs 0/0, 0/1, 1/0, 1/1, one per cycle, with in_valid=1 -> (y[0],c[0]) = (0,0), (1,0), (1,0), (0,1) on successive cycles (half-adder truth table).
REQ-029 WIDTH=4, a=4'b1100, b=4'b1010: op=00 -> y=4'b1000, c=0; op=01 -> y=4'b0110, c=0.
REQ-030 WIDTH=4, op=11, a=4'hF, b=4'h1 -> y=4'h0, c=4'b1111 (full wrap, carry-out 1); a=4'h5, b=4'h3 -> y=4'h8, c=4'b0111.
REQ-031 Streaming: four back-to-back in_valid cycles, then in_valid=0 -> out_valid=1 for four cycles; y and c hold the last result once out_valid returns to 0.
REQ-032 Assert rst asynchronously between edges while out_valid=1 -> y, c and out_valid read 0 before the next edge; after release, output stays 0 until a valid sample.
REQ-033 Exhaustive WIDTH=4 sweep of all a, b in op=11 -> {c[3], y} equals a+b for all 256 pairs.

Source files
------------

// File: rtl/gate_adder_unit_if.sv
// Operand/result bundle for gate_adder_unit: request fields from the master,
// registered result and carry vector back from the slave.
interface gate_adder_unit_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] c;
    logic             out_valid;

    modport master (
        output in_valid, a, b, op,
        input  y, c, out_valid
    );

    modport slave (
        input  in_valid, a, b, op,
        output y, c, out_valid
    );
endinterface

// File: rtl/gate_adder_unit.sv
// Bitwise AND/XOR, per-bit half adders and a ripple-carry adder built only from
// 2-input AND and XOR cells, with a single registered output stage.
module gate_adder_unit #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    gate_adder_unit_if.slave bus
);
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] rca_sum;
    logic [WIDTH-1:0] rca_carry;

    assign prop = bus.a ^ bus.b;
    assign gen  = bus.a & bus.b;

    // Stage 0 is a half adder; the two carry terms of each full adder can never
    // both be 1, so XOR stands in for the usual OR.
    assign rca_sum[0]   = prop[0];
    assign rca_carry[0] = gen[0];

    for (genvar i = 1; i < WIDTH; i++) begin : g_full_adder
        assign rca_sum[i]   = prop[i] ^ rca_carry[i-1];
        assign rca_carry[i] = gen[i] ^ (rca_carry[i-1] & prop[i]);
    end

    // One-hot operation decode; inversion is XOR with 1 so the datapath stays
    // within the two allowed cell types.
    logic op0_n;
    logic op1_n;
    logic sel_and;
    logic sel_xor;
    logic sel_ha;
    logic sel_rca;

    assign op0_n   = bus.op[0] ^ 1'b1;
    assign op1_n   = bus.op[1] ^ 1'b1;
    assign sel_and = op1_n & op0_n;
    assign sel_xor = bus.op[1] ^ bus.op[0];
    assign sel_ha  = bus.op[1] & op0_n;
    assign sel_rca = bus.op[1] & bus.op[0];

    // Selected terms are mutually exclusive, so XOR merges them like a mux.
    logic [WIDTH-1:0] y_next;
    logic [WIDTH-1:0] c_next;

    assign y_next = ({WIDTH{sel_and}} & gen)
                  ^ ({WIDTH{sel_xor}} & prop)
                  ^ ({WIDTH{sel_rca}} & rca_sum);
    assign c_next = ({WIDTH{sel_ha}}  & gen)
                  ^ ({WIDTH{sel_rca}} & rca_carry);

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.y         <= '0;
            bus.c         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.y <= y_next;
                bus.c <= c_next;
            end
        end
    end
endmodule

// File: tb/tb_gate_adder_unit.sv
// Scoreboard bench for gate_adder_unit (WIDTH=4): directed vectors with
// hand-computed results, an exhaustive adder sweep and async reset cases.
module tb_gate_adder_unit;
    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] c;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t last_exp;

    gate_adder_unit_if #(.WIDTH(WIDTH)) bus ();

    gate_adder_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle that presents a result consumes one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_y", 32'(bus.y), 32'(e.y));
                    check("result_c", 32'(bus.c), 32'(e.c));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] y_e, input logic [3:0] c_e);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        e.y          = y_e;
        e.c          = c_e;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 4'h0;
        bus.b        = 4'h0;
    endtask

    task automatic check_idle_hold(input string name);
        @(negedge clk);
        @(negedge clk);
        check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_y_hold"}, 32'(bus.y), 32'(last_exp.y));
        check({name, "_c_hold"}, 32'(bus.c), 32'(last_exp.c));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        last_exp     = '0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.a        = 4'h0;
        bus.b        = 4'h0;

        // Outputs clear from the reset edge alone, before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("reset_y", 32'(bus.y), 32'd0);
        check("reset_c", 32'(bus.c), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Half-adder truth table on bit 0, then AND/XOR/HA on a multi-bit pair.
        issue(2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        issue(2'b10, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        issue(2'b10, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        issue(2'b10, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        issue(2'b00, 4'b1100, 4'b1010, 4'b1000, 4'b0000);
        issue(2'b01, 4'b1100, 4'b1010, 4'b0110, 4'b0000);
        issue(2'b10, 4'b1100, 4'b1010, 4'b0110, 4'b1000);
        // Ripple-carry: full wrap, mid carry chain, zero.
        issue(2'b11, 4'hF, 4'h1, 4'h0, 4'b1111);
        issue(2'b11, 4'h5, 4'h3, 4'h8, 4'b0111);
        issue(2'b11, 4'h0, 4'h0, 4'h0, 4'b0000);
        issue(2'b01, 4'hF, 4'h0, 4'hF, 4'b0000);
        idle();
        check_idle_hold("after_directed");

        // Four back-to-back results, then outputs must hold the last one.
        issue(2'b11, 4'h7, 4'h1, 4'h8, 4'b0111);
        issue(2'b00, 4'hF, 4'h5, 4'h5, 4'b0000);
        issue(2'b11, 4'h9, 4'h9, 4'h2, 4'b1001);
        issue(2'b10, 4'h6, 4'h3, 4'h5, 4'b0010);
        idle();
        check_idle_hold("after_stream");

        // Exhaustive adder sweep; carry model is per-prefix addition.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                logic [3:0] cv;
                int         s;
                s = ai + bi;
                for (int i = 0; i < WIDTH; i++) begin
                    int mask;
                    mask  = (1 << (i + 1)) - 1;
                    cv[i] = 1'(((ai & mask) + (bi & mask)) >> (i + 1));
                end
                issue(2'b11, 4'(ai), 4'(bi), 4'(s), cv);
            end
        end
        idle();
        check_idle_hold("after_sweep");

        // Mid-stream reset between edges discards the in-flight result.
        issue(2'b11, 4'h5, 4'h3, 4'h8, 4'b0111);
        issue(2'b00, 4'hC, 4'hA, 4'h8, 4'b0000);
        @(posedge clk);
        #2;
        check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        last_exp = '0;
        #1;
        check("async_reset_y", 32'(bus.y), 32'd0);
        check("async_reset_c", 32'(bus.c), 32'd0);
        check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
        // in_valid held high across an edge during reset is ignored.
        @(posedge clk);
        #1;
        check("in_reset_y", 32'(bus.y), 32'd0);
        check("in_reset_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        check_idle_hold("after_release");
        issue(2'b11, 4'hA, 4'h7, 4'h1, 4'b1110);
        idle();
        check_idle_hold("post_reset_result");

        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
